// File: rtl/tap_mac_pkg.sv
// Shared widths and types for the four-tap multiply-accumulate stage.
package tap_mac_pkg;
    localparam int TAP_W  = 8;
    localparam int COEF_W = 8;
    localparam int PROD_W = 17;
    localparam int SUM_W  = 18;
    localparam int OUT_W  = 16;
    localparam int N_TAPS = 4;

    typedef logic signed [COEF_W-1:0] coef_arr_t [N_TAPS];
endpackage

// File: rtl/tap_mac_mul.sv
// Registered unsigned-tap by signed-coefficient product.
module tap_mac_mul
    import tap_mac_pkg::*;
(
    input  logic                     clk,
    input  logic                     en,
    input  logic [TAP_W-1:0]         tap,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [PROD_W-1:0] prod
);
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;

    assign a = {{(PROD_W-TAP_W){1'b0}}, tap};
    assign b = {{(PROD_W-COEF_W){coef[COEF_W-1]}}, coef};

    always_ff @(posedge clk) begin
        if (en) begin
            prod <= a * b;
        end
    end
endmodule

// File: rtl/tap_mac_stage.sv
// Two-stage 4-tap MAC with whole-pipeline stall and sticky overflow.
// Define TAP_MAC_SAT_EN to saturate out-of-range results instead of wrapping.
module tap_mac_stage
    import tap_mac_pkg::*;
#(
    parameter int RSHIFT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAP_W-1:0]         tap0,
    input  logic [TAP_W-1:0]         tap1,
    input  logic [TAP_W-1:0]         tap2,
    input  logic [TAP_W-1:0]         tap3,
    input  logic                     coef_wr,
    input  logic [1:0]               coef_sel,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     ovf
);
    localparam logic signed [SUM_W-1:0] MAXV = 18'sd32767;
    localparam logic signed [SUM_W-1:0] MINV = -18'sd32768;

    logic [TAP_W-1:0]         tap_v [N_TAPS];
    logic signed [PROD_W-1:0] prod  [N_TAPS];
    coef_arr_t                coef;
    logic                     advance;
    logic                     v1;
    logic signed [SUM_W-1:0]  sum_c;
    logic signed [SUM_W-1:0]  shifted;
    logic                     oor;
    logic signed [OUT_W-1:0]  narrow;

    assign tap_v[0] = tap0;
    assign tap_v[1] = tap1;
    assign tap_v[2] = tap2;
    assign tap_v[3] = tap3;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Products read the registered coefficients, so a same-cycle write is seen next sample.
    for (genvar i = 0; i < N_TAPS; i++) begin : g_mul
        tap_mac_mul u_mul (
            .clk  (clk),
            .en   (advance && in_valid),
            .tap  (tap_v[i]),
            .coef (coef[i]),
            .prod (prod[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coef[0] <= 8'sd1;
            for (int i = 1; i < N_TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_wr) begin
            coef[coef_sel] <= coef_data;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            sum_c = sum_c + {{(SUM_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
        end
        shifted = sum_c >>> RSHIFT;
        oor     = (shifted > MAXV) || (shifted < MINV);
`ifdef TAP_MAC_SAT_EN
        if (oor) begin
            narrow = shifted[SUM_W-1] ? 16'sh8000 : 16'sh7fff;
        end else begin
            narrow = shifted[OUT_W-1:0];
        end
`else
        narrow = shifted[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ovf       <= 1'b0;
        end else if (advance) begin
            v1        <= in_valid;
            out_valid <= v1;
            if (v1) begin
                out_data <= narrow;
                if (oor) begin
                    ovf <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tap_mac_stage.sv
// Directed bench for tap_mac_stage: RSHIFT=0 and RSHIFT=2 instances share stimulus.
module tb_tap_mac_stage;
    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready, in_ready2;
    logic [7:0]        tap0, tap1, tap2, tap3;
    logic              coef_wr;
    logic [1:0]        coef_sel;
    logic signed [7:0] coef_data;
    logic              out_valid, out_valid2;
    logic              out_ready;
    logic signed [15:0] out_data, out_data2;
    logic              ovf, ovf2;

    typedef struct {
        int s0;
        int s2;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   mc[4];
    bit   xo0, xo2;
    bit   hold_chk = 0;
    logic signed [15:0] held;
    bit   rdy;

    always #5 clk = ~clk;

    tap_mac_stage #(.RSHIFT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
        .coef_wr(coef_wr), .coef_sel(coef_sel), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .ovf(ovf)
    );

    tap_mac_stage #(.RSHIFT(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
        .coef_wr(coef_wr), .coef_sel(coef_sel), .coef_data(coef_data),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .ovf(ovf2)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int msum(input int sh);
        int acc;
        acc = int'(tap0) * mc[0] + int'(tap1) * mc[1]
            + int'(tap2) * mc[2] + int'(tap3) * mc[3];
        return acc >>> sh;
    endfunction

    function automatic bit oor(input int s);
        return (s > 32767) || (s < -32768);
    endfunction

    function automatic int narrow(input int s);
        logic signed [15:0] w;
`ifdef TAP_MAC_SAT_EN
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
`endif
        w = s[15:0];
        return int'(w);
    endfunction

    // Scoreboard side: pop on each transfer, and check holding while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold_chk = 0;
        end else begin
            if (hold_chk) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    xo0 = xo0 | oor(e.s0);
                    xo2 = xo2 | oor(e.s2);
                    check("data_rs0", out_data, narrow(e.s0));
                    check("data_rs2", out_data2, narrow(e.s2));
                    check("ovf_rs0", ovf, xo0);
                    check("ovf_rs2", ovf2, xo2);
                    check("valid_rs2", out_valid2, 1);
                end
            end
            hold_chk = out_valid && !out_ready;
            held = out_data;
        end
    end

    task automatic cyc(input bit v, input int a, input int b, input int c,
                       input int d, input bit w, input int s, input int dat,
                       output bit r);
        in_valid  = v;
        tap0      = a[7:0];
        tap1      = b[7:0];
        tap2      = c[7:0];
        tap3      = d[7:0];
        coef_wr   = w;
        coef_sel  = s[1:0];
        coef_data = dat[7:0];
        @(negedge clk);
        r = in_ready;
        if (v && in_ready) q.push_back('{msum(0), msum(2)});
        @(posedge clk);
        #1;
        if (w) mc[s] = int'($signed(dat[7:0]));
        in_valid = 0;
        coef_wr  = 0;
    endtask

    task automatic model_reset();
        q.delete();
        mc  = '{1, 0, 0, 0};
        xo0 = 0;
        xo2 = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    initial begin
        reset = 1; in_valid = 0; out_ready = 1; coef_wr = 0;
        coef_sel = 0; coef_data = 0;
        tap0 = 0; tap1 = 0; tap2 = 0; tap3 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Pass-through of tap0 with exact two-cycle latency.
        cyc(1, 'h7F, 'h10, 'h20, 'h30, 0, 0, 0, rdy);
        check("p1_ready", rdy, 1);
        @(negedge clk);
        check("lat_cycle1", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_cycle2", out_valid, 1);
        check("passthru", out_data, 127);
        @(posedge clk);
        #1;
        idle(2);

        // Mixed-sign coefficients, then same-cycle coefficient write.
        cyc(0, 0, 0, 0, 0, 1, 0, 1, rdy);
        cyc(0, 0, 0, 0, 0, 1, 1, -1, rdy);
        cyc(0, 0, 0, 0, 0, 1, 2, 2, rdy);
        cyc(0, 0, 0, 0, 0, 1, 3, -2, rdy);
        cyc(1, 10, 20, 30, 40, 0, 0, 0, rdy);
        cyc(1, 10, 20, 30, 40, 1, 0, 5, rdy);
        cyc(1, 10, 20, 30, 40, 0, 0, 0, rdy);
        idle(3);

        // Overflow: all coefficients 127, all taps 255.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, i, 127, rdy);
        cyc(1, 255, 255, 255, 255, 0, 0, 0, rdy);
        idle(3);
        check("ovf_sticky", ovf, 1);

        // Continuous stream with a 3-cycle downstream stall and live coef writes.
        for (int i = 0; i < 12; i++) begin
            out_ready = !(i >= 3 && i <= 5);
            cyc(1, $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255),
                1, i % 4, $urandom_range(0, 255), rdy);
            if (i >= 3 && i <= 5) check("stall_ready", rdy, 0);
            if (i < 3) check("flow_ready", rdy, 1);
        end
        out_ready = 1;
        idle(4);

        // Reset with two samples in flight.
        cyc(1, 1, 2, 3, 4, 0, 0, 0, rdy);
        cyc(1, 5, 6, 7, 8, 0, 0, 0, rdy);
        reset = 1;
        model_reset();
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        cyc(1, 9, 200, 200, 200, 0, 0, 0, rdy);
        idle(3);

        // Most negative coefficient on full-scale tap0.
        cyc(0, 0, 0, 0, 0, 1, 0, -128, rdy);
        cyc(1, 255, 0, 0, 0, 0, 0, 0, rdy);
        idle(3);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        check("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tap_mac_stage.md
TAP_MAC_STAGE -- requirements
Module: tap_mac_stage

Interface
REQ-001 Parameter RSHIFT, default 0, arithmetic right shift (0..2) applied to the 18-bit sum before output narrowing.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  tap sample valid; driven by the same strobe as the upstream shift enable.
REQ-005 in_ready  output  1  stage accepts a sample this cycle.
REQ-006 tap0, tap1, tap2, tap3  input  8 each  unsigned tap bytes: tap0 = word 15, tap1 = word 31, tap2 = word 47, tap3 = word 63 of the 8x64 delay line.
REQ-007 coef_wr  input  1  coefficient write strobe.
REQ-008 coef_sel  input  2  coefficient index 0..3.
REQ-009 coef_data  input  8  signed two's-complement coefficient.
REQ-010 out_valid  output  1  out_data holds a result.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  16  signed result.
REQ-013 ovf  output  1  sticky flag: set when any result exceeded the signed 16-bit range.

Function
REQ-014 A sample SHALL transfer when in_valid && in_ready.
REQ-015 Stage 1 SHALL register four products p[i] = tap_i (zero-extended) * coef[i] (signed), each 17-bit signed.
REQ-016 Stage 2 SHALL register sum = p0+p1+p2+p3 as an 18-bit signed value, followed by arithmetic shift right by RSHIFT.
REQ-017 Latency SHALL be exactly 2 cycles from accepted input to out_valid when out_ready stays high.
REQ-018 Pipeline SHALL stall as a whole: advance = !out_valid || out_ready; in_ready = advance.
REQ-019 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-020 Bubbles (in_valid low) SHALL propagate as invalid stages; throughput SHALL be 1 sample/cycle without stalls.
REQ-021 A coefficient write SHALL update coef[coef_sel] at the clock edge; a sample accepted in the same cycle SHALL use the old coefficient, and a sample accepted on any later cycle SHALL use the new one.
REQ-022 Coefficient writes SHALL be accepted regardless of the stall state.
REQ-023 ovf SHALL be set when a transferred result's shifted sum lies outside -32768..32767, and SHALL clear only on reset.

Reset
REQ-024 Reset SHALL clear all stage valid bits, out_valid = 0, out_data = 0, and ovf = 0.
REQ-025 Reset SHALL load coef0 = 1 and coef1 = coef2 = coef3 = 0, so tap0 passes through.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight samples; in_ready SHALL be 1 on the first cycle after reset.

Configuration
REQ-027 With macro TAP_MAC_SAT_EN defined, an out-of-range result SHALL saturate to 32767 or -32768.
REQ-028 Without TAP_MAC_SAT_EN, out_data SHALL be the low 16 bits of the shifted sum (wrap); ovf SHALL behave identically in both builds.

Structure
REQ-029 A shared package SHALL hold: TAP_W=8, COEF_W=8, PROD_W=17, SUM_W=18, OUT_W=16, the number of taps (4), and the coefficient-array typedef.
REQ-030 One sub-module, tap_mac_mul, SHALL implement a single unsigned-by-signed registered product; it is instantiated four times.

Verification
REQ-031 After reset, taps = {0x7F, 0x10, 0x20, 0x30} with in_valid high for 1 cycle -> out_valid 2 cycles later with out_data = 127.
REQ-032 Coefficients {1, -1, 2, -2}, taps = {10, 20, 30, 40} -> out_data = -30; coefficient written in the same cycle as a sample -> that sample uses the old value.
REQ-033 Coefficients all 127, taps all 255 (sum 129540) -> SAT build: out_data = 32767, ovf = 1; wrap build: out_data = 0xFA04, ovf = 1.
REQ-034 Continuous input with out_ready low for 3 cycles -> out_data held, in_ready low, no sample lost or duplicated; order preserved against a scoreboard.
REQ-035 Reset asserted with 2 samples in flight -> out_valid low the next cycle, coefficients back to {1, 0, 0, 0}, ovf = 0.
REQ-036 RSHIFT = 2, coefficients {-128, 0, 0, 0}, tap0 = 255 -> out_data = -8160.
